// File: rtl/bru_wb_resolver_if.sv
// BRU result, dispatch prediction, ROB writeback and front-end redirect signals
// of the writeback-side branch resolver, bundled with the resolver as the slave.
interface bru_wb_resolver_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ITAG_W = 8
);
  logic              wb_valid_i;
  logic              wb_ready_o;
  logic [XLEN-1:0]   wb_data_i;
  logic [XLEN-1:0]   wb_branchaddr_i;
  logic              wb_jump_i;
  logic [ITAG_W-1:0] wb_itag_i;

  logic              pred_we_i;
  logic [ITAG_W-1:0] pred_itag_i;
  logic              pred_taken_i;
  logic [XLEN-1:0]   pred_target_i;
  logic [XLEN-1:0]   pred_fallthru_i;

  logic              rob_valid_o;
  logic              rob_ready_i;
  logic [ITAG_W-1:0] rob_itag_o;
  logic [XLEN-1:0]   rob_data_o;
  logic              rob_mispred_o;

  logic              redir_valid_o;
  logic              redir_ack_i;
  logic [XLEN-1:0]   redir_pc_o;

  modport slave (
    input  wb_valid_i, wb_data_i, wb_branchaddr_i, wb_jump_i, wb_itag_i,
    input  pred_we_i, pred_itag_i, pred_taken_i, pred_target_i, pred_fallthru_i,
    input  rob_ready_i, redir_ack_i,
    output wb_ready_o, rob_valid_o, rob_itag_o, rob_data_o, rob_mispred_o,
    output redir_valid_o, redir_pc_o
  );

  modport master (
    output wb_valid_i, wb_data_i, wb_branchaddr_i, wb_jump_i, wb_itag_i,
    output pred_we_i, pred_itag_i, pred_taken_i, pred_target_i, pred_fallthru_i,
    output rob_ready_i, redir_ack_i,
    input  wb_ready_o, rob_valid_o, rob_itag_o, rob_data_o, rob_mispred_o,
    input  redir_valid_o, redir_pc_o
  );
endinterface

// File: rtl/bru_wb_resolver.sv
// Resolves BRU results against the dispatch-time prediction table, forwards the
// completion to the ROB and raises a front-end redirect on mispredict.
module bru_wb_resolver #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ITAG_W = 8
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic flush_i,
  bru_wb_resolver_if.slave bus
);

  localparam int unsigned DEPTH = 32'(1) << ITAG_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FULL    = 2'd1,
    S_FULL_RD = 2'd2
  } state_e;

  state_e            r_state;
  logic              r_rob_valid;
  logic              r_redir_valid;
  logic [ITAG_W-1:0] r_rob_itag;
  logic [XLEN-1:0]   r_rob_data;
  logic              r_rob_mispred;
  logic [XLEN-1:0]   r_redir_pc;

  logic [DEPTH-1:0]  r_tbl_vld;
  logic [DEPTH-1:0]  r_tbl_taken;
  logic [XLEN-1:0]   r_tbl_target   [DEPTH];
  logic [XLEN-1:0]   r_tbl_fallthru [DEPTH];

  logic              w_wb_ready;
  logic              w_accept;
  logic              w_ent_vld;
  logic              w_ent_taken;
  logic [XLEN-1:0]   w_ent_target;
  logic [XLEN-1:0]   w_ent_fallthru;
  logic              w_mispred;
  logic [XLEN-1:0]   w_redir_pc;
  logic              w_rob_done;
  logic              w_redir_done;

  // Ready is a function of the output register state; flush blocks intake for its cycle.
  always_comb begin
    w_wb_ready = 1'b0;
    unique case (r_state)
      S_IDLE:    w_wb_ready = 1'b1;
      S_FULL:    w_wb_ready = bus.rob_ready_i;
      S_FULL_RD: w_wb_ready = 1'b0;
      default:   w_wb_ready = 1'b0;
    endcase
    if (flush_i) w_wb_ready = 1'b0;
  end

  assign w_accept = bus.wb_valid_i & w_wb_ready;

  // A missing entry reads as predicted not-taken.
  assign w_ent_vld      = r_tbl_vld[bus.wb_itag_i];
  assign w_ent_taken    = w_ent_vld & r_tbl_taken[bus.wb_itag_i];
  assign w_ent_target   = r_tbl_target[bus.wb_itag_i];
  assign w_ent_fallthru = r_tbl_fallthru[bus.wb_itag_i];

  assign w_mispred  = (bus.wb_jump_i != w_ent_taken) |
                      (bus.wb_jump_i & w_ent_taken & (bus.wb_branchaddr_i != w_ent_target));
  assign w_redir_pc = bus.wb_jump_i ? bus.wb_branchaddr_i : w_ent_fallthru;

  assign w_rob_done   = ~r_rob_valid | bus.rob_ready_i;
  assign w_redir_done = ~r_redir_valid | bus.redir_ack_i;

  // Prediction payload storage; validity lives in r_tbl_vld.
  always_ff @(posedge clk_i) begin
    if (bus.pred_we_i && !flush_i) begin
      r_tbl_taken[bus.pred_itag_i]    <= bus.pred_taken_i;
      r_tbl_target[bus.pred_itag_i]   <= bus.pred_target_i;
      r_tbl_fallthru[bus.pred_itag_i] <= bus.pred_fallthru_i;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state       <= S_IDLE;
      r_rob_valid   <= 1'b0;
      r_redir_valid <= 1'b0;
      r_rob_itag    <= '0;
      r_rob_data    <= '0;
      r_rob_mispred <= 1'b0;
      r_redir_pc    <= '0;
      r_tbl_vld     <= '0;
    end else if (flush_i) begin
      r_state       <= S_IDLE;
      r_rob_valid   <= 1'b0;
      r_redir_valid <= 1'b0;
      r_tbl_vld     <= '0;
    end else begin
      // Clear on accept first so a same-cycle prediction write to that itag wins.
      if (w_accept)      r_tbl_vld[bus.wb_itag_i]   <= 1'b0;
      if (bus.pred_we_i) r_tbl_vld[bus.pred_itag_i] <= 1'b1;

      if (w_accept) begin
        r_rob_itag    <= bus.wb_itag_i;
        r_rob_data    <= bus.wb_data_i;
        r_rob_mispred <= w_mispred;
        r_redir_pc    <= w_redir_pc;
        r_rob_valid   <= 1'b1;
        r_redir_valid <= w_mispred;
        r_state       <= w_mispred ? S_FULL_RD : S_FULL;
      end else begin
        unique case (r_state)
          S_IDLE: ;
          S_FULL: begin
            if (bus.rob_ready_i) begin
              r_rob_valid <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
          S_FULL_RD: begin
            if (r_rob_valid && bus.rob_ready_i)   r_rob_valid   <= 1'b0;
            if (r_redir_valid && bus.redir_ack_i) r_redir_valid <= 1'b0;
            if (w_rob_done && w_redir_done)       r_state       <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.wb_ready_o    = w_wb_ready;
  assign bus.rob_valid_o   = r_rob_valid;
  assign bus.rob_itag_o    = r_rob_itag;
  assign bus.rob_data_o    = r_rob_data;
  assign bus.rob_mispred_o = r_rob_mispred;
  assign bus.redir_valid_o = r_redir_valid;
  assign bus.redir_pc_o    = r_redir_pc;

endmodule

// File: tb/tb_bru_wb_resolver.sv
// Scoreboard bench for bru_wb_resolver: directed stimulus pushes expected
// completions/redirects, a negedge monitor pops them on each handshake.
module tb_bru_wb_resolver;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ITAG_W = 8;

  typedef struct {
    logic [ITAG_W-1:0] itag;
    logic [XLEN-1:0]   data;
    logic              mis;
  } exp_t;

  logic clk;
  logic arstn;
  logic flush;
  int   n_tests;
  int   n_fail;
  int   cyc;
  exp_t rob_q[$];
  logic [XLEN-1:0] redir_q[$];
  exp_t mon_e;
  logic [XLEN-1:0] mon_pc;
  int   a1, a2, a3;

  bru_wb_resolver_if #(.XLEN(XLEN), .ITAG_W(ITAG_W)) bus ();

  bru_wb_resolver #(.XLEN(XLEN), .ITAG_W(ITAG_W)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .flush_i (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every ROB or redirect handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (arstn) begin
      if (bus.rob_valid_o && bus.rob_ready_i) begin
        if (rob_q.size() == 0) chk("rob_unexpected", 1, 0);
        else begin
          mon_e = rob_q.pop_front();
          chk("rob_itag", XLEN'(bus.rob_itag_o), XLEN'(mon_e.itag));
          chk("rob_data", bus.rob_data_o, mon_e.data);
          chk("rob_mispred", XLEN'(bus.rob_mispred_o), XLEN'(mon_e.mis));
        end
      end
      if (bus.redir_valid_o && bus.redir_ack_i) begin
        if (redir_q.size() == 0) chk("redir_unexpected", 1, 0);
        else begin
          mon_pc = redir_q.pop_front();
          chk("redir_pc", bus.redir_pc_o, mon_pc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pred(input logic [ITAG_W-1:0] itag, input logic taken,
                      input logic [XLEN-1:0] tgt, input logic [XLEN-1:0] ft);
    bus.pred_we_i       = 1'b1;
    bus.pred_itag_i     = itag;
    bus.pred_taken_i    = taken;
    bus.pred_target_i   = tgt;
    bus.pred_fallthru_i = ft;
    step();
    bus.pred_we_i = 1'b0;
  endtask

  // Issues one BRU result and returns #1 after the accepting edge.
  task automatic send_wb(input logic [ITAG_W-1:0] itag, input logic jump,
                         input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data,
                         input logic mis, input logic [XLEN-1:0] rpc, output int acc);
    exp_t e;
    bit   done;
    e.itag = itag;
    e.data = data;
    e.mis  = mis;
    rob_q.push_back(e);
    if (mis) redir_q.push_back(rpc);
    bus.wb_valid_i      = 1'b1;
    bus.wb_itag_i       = itag;
    bus.wb_jump_i       = jump;
    bus.wb_branchaddr_i = addr;
    bus.wb_data_i       = data;
    done = 1'b0;
    acc  = -1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.wb_ready_o) begin
        @(posedge clk);
        #1;
        acc  = cyc;
        done = 1'b1;
      end
    end
    bus.wb_valid_i = 1'b0;
    if (!done) chk("wb_accept_timeout", 0, 1);
  endtask

  initial begin
    int acc;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    arstn   = 1'b0;
    flush   = 1'b0;
    bus.wb_valid_i = 1'b0; bus.wb_itag_i = '0; bus.wb_jump_i = 1'b0;
    bus.wb_branchaddr_i = '0; bus.wb_data_i = '0;
    bus.pred_we_i = 1'b0; bus.pred_itag_i = '0; bus.pred_taken_i = 1'b0;
    bus.pred_target_i = '0; bus.pred_fallthru_i = '0;
    bus.rob_ready_i = 1'b0; bus.redir_ack_i = 1'b0;

    repeat (3) step();
    chk("reset_rob_valid", XLEN'(bus.rob_valid_o), 0);
    chk("reset_redir_valid", XLEN'(bus.redir_valid_o), 0);
    chk("reset_wb_ready", XLEN'(bus.wb_ready_o), 1);
    @(negedge clk);
    arstn = 1'b1;
    step();

    // 1: correctly predicted taken branch
    bus.rob_ready_i = 1'b1;
    pred(8'd3, 1'b1, 64'h1000, 64'h1004);
    send_wb(8'd3, 1'b1, 64'h1000, 64'h1004, 1'b0, 64'h0, acc);
    chk("t1_rob_valid", XLEN'(bus.rob_valid_o), 1);
    chk("t1_redir_valid", XLEN'(bus.redir_valid_o), 0);
    step();
    chk("t1_rob_drop", XLEN'(bus.rob_valid_o), 0);

    // 2: predicted not-taken, resolved taken
    bus.rob_ready_i = 1'b0;
    bus.redir_ack_i = 1'b0;
    pred(8'd5, 1'b0, 64'h0, 64'h2004);
    send_wb(8'd5, 1'b1, 64'h3000, 64'h2004, 1'b1, 64'h3000, acc);
    chk("t2_redir_valid", XLEN'(bus.redir_valid_o), 1);
    chk("t2_redir_pc", bus.redir_pc_o, 64'h3000);
    chk("t2_wb_ready", XLEN'(bus.wb_ready_o), 0);
    step();
    chk("t2_hold_pc", bus.redir_pc_o, 64'h3000);
    bus.rob_ready_i = 1'b1;
    step();
    bus.rob_ready_i = 1'b0;
    chk("t2_rob_drop", XLEN'(bus.rob_valid_o), 0);
    chk("t2_redir_held", XLEN'(bus.redir_valid_o), 1);
    chk("t2_wb_ready_wait", XLEN'(bus.wb_ready_o), 0);
    bus.redir_ack_i = 1'b1;
    step();
    bus.redir_ack_i = 1'b0;
    chk("t2_redir_drop", XLEN'(bus.redir_valid_o), 0);
    chk("t2_idle_ready", XLEN'(bus.wb_ready_o), 1);

    // 3: predicted taken, resolved not-taken; redirect acked before ROB
    pred(8'd7, 1'b1, 64'h40, 64'h84);
    send_wb(8'd7, 1'b0, 64'h99, 64'h84, 1'b1, 64'h84, acc);
    chk("t3_redir_pc", bus.redir_pc_o, 64'h84);
    bus.redir_ack_i = 1'b1;
    step();
    bus.redir_ack_i = 1'b0;
    chk("t3_redir_drop", XLEN'(bus.redir_valid_o), 0);
    chk("t3_rob_held", XLEN'(bus.rob_valid_o), 1);
    chk("t3_wb_ready", XLEN'(bus.wb_ready_o), 0);
    step();
    step();
    chk("t3_rob_still", XLEN'(bus.rob_valid_o), 1);
    bus.rob_ready_i = 1'b1;
    step();
    bus.rob_ready_i = 1'b0;
    chk("t3_rob_drop", XLEN'(bus.rob_valid_o), 0);
    chk("t3_idle_ready", XLEN'(bus.wb_ready_o), 1);

    // 4: back-to-back completions, then ROB stall
    pred(8'd1, 1'b0, 64'h0, 64'h104);
    pred(8'd2, 1'b0, 64'h0, 64'h204);
    pred(8'd3, 1'b0, 64'h0, 64'h304);
    bus.rob_ready_i = 1'b1;
    send_wb(8'd1, 1'b0, 64'h0, 64'h104, 1'b0, 64'h0, a1);
    send_wb(8'd2, 1'b0, 64'h0, 64'h204, 1'b0, 64'h0, a2);
    send_wb(8'd3, 1'b0, 64'h0, 64'h304, 1'b0, 64'h0, a3);
    bus.rob_ready_i = 1'b0;
    chk("t4_gap12", XLEN'(a2 - a1), 1);
    chk("t4_gap23", XLEN'(a3 - a2), 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t4_stall_valid", XLEN'(bus.rob_valid_o), 1);
      chk("t4_stall_itag", XLEN'(bus.rob_itag_o), 3);
      chk("t4_stall_data", bus.rob_data_o, 64'h304);
      chk("t4_stall_ready", XLEN'(bus.wb_ready_o), 0);
    end
    bus.rob_ready_i = 1'b1;
    step();
    chk("t4_drain", XLEN'(bus.rob_valid_o), 0);

    // 5: flush in FULL_RD clears outputs and table; same-cycle pred ignored
    bus.rob_ready_i = 1'b0;
    bus.redir_ack_i = 1'b0;
    pred(8'd10, 1'b0, 64'h0, 64'h504);
    pred(8'd11, 1'b1, 64'h600, 64'h604);
    send_wb(8'd11, 1'b0, 64'h123, 64'h604, 1'b1, 64'h604, acc);
    step();
    flush = 1'b1;
    bus.pred_we_i = 1'b1; bus.pred_itag_i = 8'd12; bus.pred_taken_i = 1'b1;
    bus.pred_target_i = 64'h700; bus.pred_fallthru_i = 64'h704;
    #1;
    chk("t5_flush_ready", XLEN'(bus.wb_ready_o), 0);
    step();
    flush = 1'b0;
    bus.pred_we_i = 1'b0;
    rob_q.delete();
    redir_q.delete();
    chk("t5_rob_flushed", XLEN'(bus.rob_valid_o), 0);
    chk("t5_redir_flushed", XLEN'(bus.redir_valid_o), 0);
    bus.rob_ready_i = 1'b1;
    bus.redir_ack_i = 1'b1;
    send_wb(8'd10, 1'b1, 64'h700, 64'h504, 1'b1, 64'h700, acc);
    step();
    send_wb(8'd12, 1'b0, 64'hABC, 64'h1234, 1'b0, 64'h0, acc);
    step();

    // 6: async reset during FULL, then same-cycle write/accept on itag 9
    bus.rob_ready_i = 1'b0;
    pred(8'd20, 1'b0, 64'h0, 64'h2004);
    send_wb(8'd20, 1'b0, 64'h55, 64'h2004, 1'b0, 64'h0, acc);
    chk("t6_full", XLEN'(bus.rob_valid_o), 1);
    #2;
    arstn = 1'b0;
    #1;
    chk("t6_async_rob", XLEN'(bus.rob_valid_o), 0);
    chk("t6_async_redir", XLEN'(bus.redir_valid_o), 0);
    rob_q.delete();
    redir_q.delete();
    @(negedge clk);
    @(negedge clk);
    arstn = 1'b1;
    step();
    chk("t6_post_reset", XLEN'(bus.rob_valid_o), 0);
    bus.rob_ready_i = 1'b1;
    pred(8'd9, 1'b0, 64'h0, 64'h904);
    bus.pred_we_i = 1'b1; bus.pred_itag_i = 8'd9; bus.pred_taken_i = 1'b1;
    bus.pred_target_i = 64'h990; bus.pred_fallthru_i = 64'h994;
    send_wb(8'd9, 1'b0, 64'h77, 64'h904, 1'b0, 64'h0, acc);
    bus.pred_we_i = 1'b0;
    step();
    send_wb(8'd9, 1'b1, 64'h990, 64'h994, 1'b0, 64'h0, acc);
    step();

    // taken/taken with a different target
    bus.redir_ack_i = 1'b1;
    pred(8'd30, 1'b1, 64'h800, 64'h804);
    send_wb(8'd30, 1'b1, 64'h808, 64'h804, 1'b1, 64'h808, acc);
    step();

    repeat (3) step();
    chk("rob_q_drained", XLEN'(rob_q.size()), 0);
    chk("redir_q_drained", XLEN'(redir_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
